// File: rtl/risc8_io_pkg.sv
// Shared definitions for the risc8 IO-mapped UART: register offsets below BASE,
// STATUS/CTRL bit positions and the serial FSM state encoding.
package risc8_io_pkg;

    localparam logic [6:0] OFS_UDR    = 7'd0;
    localparam logic [6:0] OFS_STATUS = 7'd1;
    localparam logic [6:0] OFS_CTRL   = 7'd2;
    localparam logic [6:0] OFS_BAUD   = 7'd3;

    localparam int ST_RXC  = 7;
    localparam int ST_TXC  = 6;
    localparam int ST_UDRE = 5;
    localparam int ST_FE   = 4;
    localparam int ST_DOR  = 3;

    localparam int CT_RXIE = 7;
    localparam int CT_TXIE = 5;
    localparam int CT_RXEN = 4;
    localparam int CT_TXEN = 3;

    localparam logic [7:0] CTRL_MASK = 8'hB8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // Offset from a detected start edge to the middle of the start bit.
    function automatic logic [7:0] half_period(input logic [7:0] baud);
        logic [8:0] sum;
        sum = {1'b0, baud} + 9'd1;
        return sum[8:1];
    endfunction

endpackage

// File: rtl/risc8_uart_baud.sv
// Baud-rate down counter: explicit load, automatic reload from BAUD at zero,
// one-cycle tick while running and the count is zero.
module risc8_uart_baud (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic [7:0] baud,
    output logic       tick
);

    logic [7:0] cnt_reg;

    assign tick = run && (cnt_reg == 8'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= 8'd0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (tick) begin
            cnt_reg <= baud;
        end else if (run) begin
            cnt_reg <= cnt_reg - 8'd1;
        end
    end

endmodule

// File: rtl/risc8_uart_io.sv
// IO-mapped 8N1 UART responder for the risc8 data bus: register decode with
// one-cycle registered reads, a transmit FSM and a receive FSM.
module risc8_uart_io
    import risc8_io_pkg::*;
#(
    parameter logic [6:0] BASE     = 7'h2C,
    parameter logic [7:0] BAUD_RST = 8'd103
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] io_addr,
    input  logic       wen,
    input  logic       ren,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rsel,
    output logic       tx,
    input  logic       rx,
    output logic       irq
);

    localparam logic [6:0] A_UDR    = BASE - OFS_UDR;
    localparam logic [6:0] A_STATUS = BASE - OFS_STATUS;
    localparam logic [6:0] A_CTRL   = BASE - OFS_CTRL;
    localparam logic [6:0] A_BAUD   = BASE - OFS_BAUD;

    logic [7:0] ctrl_reg, baud_reg, txbuf_reg, rxbuf_reg;
    logic       udre_reg, txc_reg, rxc_reg, fe_reg, dor_reg;
    logic       hit;
    logic [7:0] rd_val;

    uart_state_t tx_state_reg, tx_state_next;
    logic [7:0]  tx_shift_reg;
    logic [2:0]  tx_bit_reg;
    logic        tx_load, tx_finish, tx_abort, tx_bit_adv, tx_tick;

    uart_state_t rx_state_reg, rx_state_next;
    logic [7:0]  rx_shift_reg;
    logic [2:0]  rx_bit_reg;
    logic        rx_s1_reg, rx_s2_reg, rx_prev_reg;
    logic        rx_begin, rx_shift_en, rx_complete, rx_tick;

    wire txen      = ctrl_reg[CT_TXEN];
    wire rxen      = ctrl_reg[CT_RXEN];
    wire wr_udr    = wen && (io_addr == A_UDR);
    wire wr_status = wen && (io_addr == A_STATUS);
    wire rd_udr    = ren && (io_addr == A_UDR);
    wire tx_accept = wr_udr && (udre_reg || tx_load);
    wire rx_store  = rx_complete && (!rxc_reg || rd_udr);

    always_comb begin
        hit    = 1'b1;
        rd_val = 8'h00;
        case (io_addr)
            A_UDR:    rd_val = rxbuf_reg;
            A_STATUS: rd_val = {rxc_reg, txc_reg, udre_reg, fe_reg, dor_reg, 3'b000};
            A_CTRL:   rd_val = ctrl_reg;
            A_BAUD:   rd_val = baud_reg;
            default:  hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsel     <= 1'b0;
            rdata    <= 8'h00;
            ctrl_reg <= 8'h00;
            baud_reg <= BAUD_RST;
        end else begin
            rsel <= ren && hit;
            if (ren && hit) rdata <= rd_val;
            if (wen && io_addr == A_CTRL) ctrl_reg <= wdata & CTRL_MASK;
            if (wen && io_addr == A_BAUD) baud_reg <= wdata;
        end
    end

    // A completion coinciding with a UDR read refills the buffer instead of overrunning.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txbuf_reg <= 8'h00;
            rxbuf_reg <= 8'h00;
            udre_reg  <= 1'b1;
            txc_reg   <= 1'b0;
            rxc_reg   <= 1'b0;
            fe_reg    <= 1'b0;
            dor_reg   <= 1'b0;
        end else begin
            if (tx_accept) txbuf_reg <= wdata;
            if (tx_accept) udre_reg <= 1'b0;
            else if (tx_load || tx_abort) udre_reg <= 1'b1;
            if (tx_finish) txc_reg <= 1'b1;
            else if (wr_status && wdata[ST_TXC]) txc_reg <= 1'b0;
            if (rx_store) begin
                rxbuf_reg <= rx_shift_reg;
                rxc_reg   <= 1'b1;
            end else if (rd_udr) begin
                rxc_reg <= 1'b0;
            end
            if (rx_store) fe_reg <= !rx_s2_reg;
            else if (wr_status && wdata[ST_FE]) fe_reg <= 1'b0;
            if (rx_complete && !rx_store) dor_reg <= 1'b1;
            else if (wr_status && wdata[ST_DOR]) dor_reg <= 1'b0;
        end
    end

    risc8_uart_baud u_tx_baud (
        .clk(clk), .reset_n(reset_n), .run(tx_state_reg != S_IDLE),
        .load(tx_load), .load_val(baud_reg), .baud(baud_reg), .tick(tx_tick)
    );

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_load       = 1'b0;
        tx_finish     = 1'b0;
        tx_bit_adv    = 1'b0;
        tx_abort      = !txen && (tx_state_reg != S_IDLE);
        if (!txen) begin
            tx_state_next = S_IDLE;
        end else begin
            case (tx_state_reg)
                S_IDLE: if (!udre_reg) begin
                    tx_load       = 1'b1;
                    tx_state_next = S_START;
                end
                S_START: if (tx_tick) tx_state_next = S_DATA;
                S_DATA: if (tx_tick) begin
                    if (tx_bit_reg == 3'd7) tx_state_next = S_STOP;
                    else tx_bit_adv = 1'b1;
                end
                S_STOP: if (tx_tick) begin
                    if (!udre_reg) begin
                        tx_load       = 1'b1;
                        tx_state_next = S_START;
                    end else begin
                        tx_finish     = 1'b1;
                        tx_state_next = S_IDLE;
                    end
                end
                default: tx_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_reg <= S_IDLE;
            tx_shift_reg <= 8'h00;
            tx_bit_reg   <= 3'd0;
        end else begin
            tx_state_reg <= tx_state_next;
            if (tx_load) begin
                tx_shift_reg <= txbuf_reg;
                tx_bit_reg   <= 3'd0;
            end else if (tx_bit_adv) begin
                tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                tx_bit_reg   <= tx_bit_reg + 3'd1;
            end
        end
    end

    assign tx  = (tx_state_reg == S_START) ? 1'b0 :
                 (tx_state_reg == S_DATA)  ? tx_shift_reg[0] : 1'b1;
    assign irq = (rxc_reg && ctrl_reg[CT_RXIE]) || (udre_reg && ctrl_reg[CT_TXIE]);

    risc8_uart_baud u_rx_baud (
        .clk(clk), .reset_n(reset_n), .run(rx_state_reg != S_IDLE),
        .load(rx_begin), .load_val(half_period(baud_reg)), .baud(baud_reg), .tick(rx_tick)
    );

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_begin      = 1'b0;
        rx_shift_en   = 1'b0;
        rx_complete   = 1'b0;
        if (!rxen) begin
            rx_state_next = S_IDLE;
        end else begin
            case (rx_state_reg)
                S_IDLE: if (rx_prev_reg && !rx_s2_reg) begin
                    rx_begin      = 1'b1;
                    rx_state_next = S_START;
                end
                S_START: if (rx_tick) rx_state_next = rx_s2_reg ? S_IDLE : S_DATA;
                S_DATA: if (rx_tick) begin
                    rx_shift_en = 1'b1;
                    if (rx_bit_reg == 3'd7) rx_state_next = S_STOP;
                end
                S_STOP: if (rx_tick) begin
                    rx_complete   = 1'b1;
                    rx_state_next = S_IDLE;
                end
                default: rx_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_reg    <= 1'b1;
            rx_s2_reg    <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= S_IDLE;
            rx_shift_reg <= 8'h00;
            rx_bit_reg   <= 3'd0;
        end else begin
            rx_s1_reg    <= rx;
            rx_s2_reg    <= rx_s1_reg;
            rx_prev_reg  <= rx_s2_reg;
            rx_state_reg <= rx_state_next;
            if (rx_begin) begin
                rx_bit_reg <= 3'd0;
            end else if (rx_shift_en) begin
                rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
                rx_bit_reg   <= rx_bit_reg + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_risc8_uart_io.sv
// Scoreboard bench for risc8_uart_io: register reads and transmitted frames are
// queued as expectations and checked by independent monitors.
module tb_risc8_uart_io;

    localparam logic [6:0] A_UDR    = 7'h2C;
    localparam logic [6:0] A_STATUS = 7'h2B;
    localparam logic [6:0] A_CTRL   = 7'h2A;
    localparam logic [6:0] A_BAUD   = 7'h29;

    logic       clk = 1'b0;
    logic       reset_n, wen, ren, rx;
    logic [6:0] io_addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rsel, tx, irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic [7:0] tx_exp[$];
    int         start_cyc[$];
    bit         mon_en = 1'b0;
    string      mon_tag;
    logic [7:0] mon_exp;
    logic [7:0] got;
    logic       stop_bit;
    logic       start_mid;

    risc8_uart_io dut (
        .clk(clk), .reset_n(reset_n), .io_addr(io_addr), .wen(wen), .ren(ren),
        .wdata(wdata), .rdata(rdata), .rsel(rsel), .tx(tx), .rx(rx), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Read-response monitor.
    always @(negedge clk) begin
        if (reset_n && rsel) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsel: got rdata %h want no response", rdata);
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                chk(mon_tag, rdata, mon_exp);
            end
        end
    end

    // Transmit monitor, 4 clocks per bit, samples each bit in its middle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && reset_n && tx == 1'b0) begin
                start_cyc.push_back(cyc);
                repeat (2) @(negedge clk);
                start_mid = tx;
                repeat (3) @(negedge clk);
                got[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    got[i] = tx;
                end
                repeat (4) @(negedge clk);
                stop_bit = tx;
                chk("tx_start_bit", {7'd0, start_mid}, 8'h00);
                chk("tx_stop_bit", {7'd0, stop_bit}, 8'h01);
                if (tx_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected_frame: got %h want no frame", got);
                end else begin
                    mon_exp = tx_exp.pop_front();
                    chk("tx_frame", got, mon_exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        io_addr = a;
        wdata   = d;
        wen     = 1'b1;
        @(posedge clk);
        #1;
        wen = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] e, input string n);
        io_addr = a;
        ren     = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(n);
        @(posedge clk);
        #1;
        ren = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        idle(4);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(4);
        end
        rx = stop;
        idle(4);
        rx = 1'b1;
    endtask

    task automatic chk_irq(input logic e, input string n);
        @(negedge clk);
        chk(n, {7'd0, irq}, {7'd0, e});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        wen     = 1'b0;
        ren     = 1'b0;
        rx      = 1'b1;
        io_addr = 7'd0;
        wdata   = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsel", {7'd0, rsel}, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_tx", {7'd0, tx}, 8'h01);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        rd(A_STATUS, 8'h20, "status_rst");
        rd(A_BAUD, 8'd103, "baud_rst");
        rd(A_CTRL, 8'h00, "ctrl_rst");

        // Single frame, TXC exactly at the end of the stop bit.
        wr(A_BAUD, 8'd3);
        wr(A_CTRL, 8'h08);
        mon_en = 1'b1;
        tx_exp.push_back(8'hA5);
        wr(A_UDR, 8'hA5);
        rd(A_STATUS, 8'h00, "status_busy");
        idle(39);
        rd(A_STATUS, 8'h20, "status_in_stop");
        rd(A_STATUS, 8'h60, "status_txc");
        wr(A_STATUS, 8'h40);
        rd(A_STATUS, 8'h20, "status_txc_clr");

        // Double buffering and back-to-back frames; third write is dropped.
        start_cyc.delete();
        tx_exp.push_back(8'h11);
        tx_exp.push_back(8'h22);
        wr(A_UDR, 8'h11);
        wr(A_UDR, 8'h22);
        wr(A_UDR, 8'h33);
        rd(A_STATUS, 8'h00, "status_full");
        idle(90);
        chk_int("btb_frames", start_cyc.size(), 2);
        if (start_cyc.size() >= 2) chk_int("btb_gap", start_cyc[1] - start_cyc[0], 40);
        rd(A_STATUS, 8'h60, "status_btb_txc");
        wr(A_STATUS, 8'h40);

        // Receive path and interrupt enables.
        wr(A_CTRL, 8'h18);
        send_rx(8'h3C, 1'b1);
        idle(3);
        rd(A_STATUS, 8'hA0, "rx_status");
        rd(A_UDR, 8'h3C, "rx_data");
        rd(A_STATUS, 8'h20, "rx_rxc_clr");
        wr(A_CTRL, 8'h38);
        chk_irq(1'b1, "irq_txie");
        wr(A_CTRL, 8'h98);
        chk_irq(1'b0, "irq_rxie_empty");

        // Overrun, then framing error, then clearing both.
        send_rx(8'h41, 1'b1);
        idle(3);
        chk_irq(1'b1, "irq_rxc");
        send_rx(8'h42, 1'b1);
        idle(3);
        rd(A_STATUS, 8'hA8, "dor_status");
        rd(A_UDR, 8'h41, "dor_keep_first");
        send_rx(8'h55, 1'b0);
        idle(3);
        rd(A_STATUS, 8'hB8, "fe_status");
        rd(A_UDR, 8'h55, "fe_data");
        wr(A_STATUS, 8'h18);
        rd(A_STATUS, 8'h20, "fe_dor_clr");

        // Asynchronous reset during data bit 3.
        mon_en = 1'b0;
        wr(A_UDR, 8'h00);
        idle(18);
        chk("tx_bit3_low", {7'd0, tx}, 8'h00);
        reset_n = 1'b0;
        #1;
        chk("tx_async_rst", {7'd0, tx}, 8'h01);
        idle(2);
        reset_n = 1'b1;
        idle(2);
        rd(A_STATUS, 8'h20, "status_after_rst");
        rd(A_BAUD, 8'd103, "baud_after_rst");
        rd(A_CTRL, 8'h00, "ctrl_after_rst");

        // One-clock low glitch on rx must not produce a byte.
        wr(A_BAUD, 8'd3);
        wr(A_CTRL, 8'h10);
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(12);
        rd(A_STATUS, 8'h20, "glitch_no_rxc");

        idle(3);
        chk_int("rd_queue_empty", exp_q.size(), 0);
        chk_int("tx_queue_empty", tx_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
